hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the per-stage register enables and flushes for the IF/DC, DC/ALU, ALU/MEM and MEM/WB registers and the PC. It inserts one bubble on a load-use dependency and flushes the wrong-path instructions on a taken branch. It freezes the whole pipeline while the data memory has not acknowledged a request. It complements the forwarding unit, which cannot resolve load-use hazards.

## Interface

**Parameters**
- MEM_TIMEOUT, 255: consecutive MEM_WAIT cycles after which mem_timeout is raised (1..255).

**Ports**
- clk  in  1  core clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- dc_rs1  in  `RegAddrSize  rs1 of the instruction in DC.
- dc_rs2  in  `RegAddrSize  rs2 of the instruction in DC.
- dc_use_rs1  in  1  the DC instruction reads rs1.
- dc_use_rs2  in  1  the DC instruction reads rs2.
- alu_rd  in  `RegAddrSize  rd of the instruction in ALU.
- alu_is_load  in  1  the ALU instruction is a load.
- alu_br_taken  in  1  branch or jump resolved taken in ALU.
- mem_req  in  1  MEM stage has an active data-memory request.
- mem_ack  in  1  data memory completes the request this cycle.
- pc_en, if_dc_en, dc_alu_en, alu_mem_en, mem_wb_en  out  1 each  register load enables.
- if_dc_flush, dc_alu_flush  out  1 each  load a NOP into that register (these override the enables).
- pc_sel_br  out  1  PC loads the branch target.
- mem_timeout  out  1  sticky timeout flag.
- perf_stall_cnt, perf_flush_cnt  out  32 each  performance counters.

## Operation

**States:** INIT, RUN, MEM_WAIT (encoding `CtrlStateBus, 2 bits).
- INIT is entered on reset and lasts exactly one cycle after rst_n deasserts.
  - All enables are 0; if_dc_flush = dc_alu_flush = 1.
  - Next state is RUN.

**freeze = mem_req & !mem_ack**, evaluated combinationally in RUN and MEM_WAIT.
- While freeze is 1, all five enables are 0 and both flushes are 0.
- RUN → MEM_WAIT when freeze is 1.
- MEM_WAIT → RUN on the cycle mem_ack = 1. That cycle is unfrozen and processed as RUN.

**Branch** (not frozen, alu_br_taken = 1):
- pc_sel_br = 1, pc_en = 1.
- if_dc_flush = 1 and dc_alu_flush = 1.
- All other enables are 1.

**Load-use** (not frozen, no branch): a hazard exists when all of the following hold:
- alu_is_load = 1
- alu_rd ≠ 0
- (dc_use_rs1 & dc_rs1 == alu_rd) | (dc_use_rs2 & dc_rs2 == alu_rd)

On a hazard:
- pc_en = 0, if_dc_en = 0.
- dc_alu_flush = 1 (bubble).
- alu_mem_en = 1, mem_wb_en = 1.
- The stall lasts one cycle by construction: the bubble clears the ALU-stage load.

**Priority:** freeze > branch > load-use > normal.
- A branch pending during a freeze is applied on the first unfrozen cycle, because the ALU inputs are held.

**Normal:** all enables are 1; flushes and pc_sel_br are 0.

**Timeout counter** (8-bit):
- Clears on entry to MEM_WAIT.
- Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
- When it reaches MEM_TIMEOUT, mem_timeout is set.
- mem_timeout stays set until reset; the freeze continues until mem_ack.

**Reset mid-operation:** asynchronous return to INIT; all in-flight control is dropped.

## Timing

- **Output types:** all enable, flush and pc_sel_br outputs are combinational from the state and inputs, with zero-cycle latency within the current cycle.
- **Registered elements:** the state, the timeout counter, mem_timeout and the perf counters.
- **Reset values:**
  - State = INIT, counter = 0, mem_timeout = 0, perf counters = 0.
  - While rst_n = 0: all enables 0, both flushes 1, pc_sel_br 0.
- **Timeout timing:** mem_timeout rises on the clock edge at which the MEM_WAIT counter reaches MEM_TIMEOUT.
- **mem_ack handling:** mem_ack without mem_req is ignored.

## Configuration

- **HAZARD_PERF_EN defined:**
  - perf_stall_cnt increments every cycle with pc_en = 0 in RUN or MEM_WAIT.
  - perf_flush_cnt increments every cycle with if_dc_flush = 1 in RUN.
  - Both are 32-bit and wrap modulo 2^32.
- **HAZARD_PERF_EN not defined:** both ports are tied to 0 and no counter registers exist.

## Structure

- **define.v:**
  - `RegAddrSize (already present).
  - `CtrlStateBus and the state encodings `CtrlINIT, `CtrlRUN, `CtrlMEM_WAIT.
- **Sub-module lu_detect:** purely combinational load-use compare. It takes dc_rs1, dc_rs2, dc_use_rs1, dc_use_rs2, alu_rd and alu_is_load and outputs lu_hazard.
- **hazard_ctrl:** instantiates lu_detect and contains the FSM, timeout counter and perf counters.

## Test plan

- **Reset:** rst_n low for 3 cycles, then released → first cycle INIT (enables 0, flushes 1), then RUN with all enables 1.
- **Load-use:** alu_is_load = 1, alu_rd = 5, dc_rs2 = 5, dc_use_rs2 = 1 → exactly one cycle of pc_en = 0, if_dc_en = 0, dc_alu_flush = 1. Repeat with alu_rd = 0 → no stall.
- **Branch beats load-use:** alu_br_taken = 1 together with a load-use hazard → pc_sel_br = 1, both flushes = 1, pc_en = 1.
- **Memory wait:** mem_req = 1 with mem_ack low for 4 cycles and alu_br_taken = 1 → all enables 0 for 4 cycles. On the ack cycle the branch flush is applied; perf_stall_cnt = 4 with HAZARD_PERF_EN.
- **Timeout:** MEM_TIMEOUT = 3, mem_ack held low for 5 cycles → mem_timeout rises after the 3rd MEM_WAIT cycle and stays 1 after the ack. Asserting rst_n mid-wait clears it and returns to INIT.
- **Config off:** HAZARD_PERF_EN not defined → perf outputs remain 0 through all of the above.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the FSM state encoding and the control-output bundle.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        CTRL_INIT     = 2'b00,
        CTRL_RUN      = 2'b01,
        CTRL_MEM_WAIT = 2'b10
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_dc_en;
        logic dc_alu_en;
        logic alu_mem_en;
        logic mem_wb_en;
        logic if_dc_flush;
        logic dc_alu_flush;
        logic pc_sel_br;
    } ctrl_out_t;

    function automatic ctrl_out_t ctrl_idle();
        ctrl_out_t c;
        c = '0;
        c.if_dc_flush  = 1'b1;
        c.dc_alu_flush = 1'b1;
        return c;
    endfunction

    function automatic ctrl_out_t ctrl_all_en();
        ctrl_out_t c;
        c = '0;
        c.pc_en      = 1'b1;
        c.if_dc_en   = 1'b1;
        c.dc_alu_en  = 1'b1;
        c.alu_mem_en = 1'b1;
        c.mem_wb_en  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use hazard compare between the DC-stage sources
// and the destination of a load sitting in ALU.
module lu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] dc_rs1,
    input  logic [REG_ADDR_W-1:0] dc_rs2,
    input  logic                  dc_use_rs1,
    input  logic                  dc_use_rs2,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic                  alu_is_load,
    output logic                  lu_hazard
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = dc_use_rs1 && (dc_rs1 == alu_rd);
    assign hit_rs2 = dc_use_rs2 && (dc_rs2 == alu_rd);

    // x0 is never a real dependency
    assign lu_hazard = alu_is_load
                     && (alu_rd != '0)
                     && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze, branch flush, load-use bubble.
// Optional perf counters built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] dc_rs1,
    input  logic [REG_ADDR_W-1:0] dc_rs2,
    input  logic                  dc_use_rs1,
    input  logic                  dc_use_rs2,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic                  alu_is_load,
    input  logic                  alu_br_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_en,
    output logic                  if_dc_en,
    output logic                  dc_alu_en,
    output logic                  alu_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_dc_flush,
    output logic                  dc_alu_flush,
    output logic                  pc_sel_br,
    output logic                  mem_timeout,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
);

    localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);

    ctrl_state_e state;
    ctrl_state_e next_state;
    ctrl_out_t   ctrl;
    logic        lu_hazard;
    logic        freeze;
    logic [7:0]  to_cnt;
    logic [7:0]  to_cnt_inc;

    lu_detect u_lu_detect (
        .dc_rs1      (dc_rs1),
        .dc_rs2      (dc_rs2),
        .dc_use_rs1  (dc_use_rs1),
        .dc_use_rs2  (dc_use_rs2),
        .alu_rd      (alu_rd),
        .alu_is_load (alu_is_load),
        .lu_hazard   (lu_hazard)
    );

    assign freeze = mem_req && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CTRL_INIT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        ctrl       = ctrl_idle();
        unique case (state)
            CTRL_INIT: begin
                next_state = CTRL_RUN;
            end
            CTRL_RUN, CTRL_MEM_WAIT: begin
                if (freeze) begin
                    next_state = CTRL_MEM_WAIT;
                    ctrl       = '0;
                end else if (alu_br_taken) begin
                    next_state        = CTRL_RUN;
                    ctrl              = ctrl_all_en();
                    ctrl.if_dc_flush  = 1'b1;
                    ctrl.dc_alu_flush = 1'b1;
                    ctrl.pc_sel_br    = 1'b1;
                end else if (lu_hazard) begin
                    next_state        = CTRL_RUN;
                    ctrl              = ctrl_all_en();
                    ctrl.pc_en        = 1'b0;
                    ctrl.if_dc_en     = 1'b0;
                    ctrl.dc_alu_flush = 1'b1;
                end else begin
                    next_state = CTRL_RUN;
                    ctrl       = ctrl_all_en();
                end
            end
            default: begin
                next_state = CTRL_INIT;
            end
        endcase
    end

    assign pc_en        = ctrl.pc_en;
    assign if_dc_en     = ctrl.if_dc_en;
    assign dc_alu_en    = ctrl.dc_alu_en;
    assign alu_mem_en   = ctrl.alu_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_dc_flush  = ctrl.if_dc_flush;
    assign dc_alu_flush = ctrl.dc_alu_flush;
    assign pc_sel_br    = ctrl.pc_sel_br;

    // Saturating wait counter; only genuinely frozen wait cycles count
    assign to_cnt_inc = (to_cnt == TO_LIMIT) ? to_cnt : to_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= 8'd0;
            mem_timeout <= 1'b0;
        end else if (state == CTRL_RUN && next_state == CTRL_MEM_WAIT) begin
            to_cnt <= 8'd0;
        end else if (state == CTRL_MEM_WAIT && freeze) begin
            to_cnt <= to_cnt_inc;
            if (to_cnt_inc == TO_LIMIT) mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (state != CTRL_INIT && !ctrl.pc_en)
                stall_q <= stall_q + 32'd1;
            if (state != CTRL_INIT && ctrl.if_dc_flush)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT = 3).
// Output bundle order: pc,if_dc,dc_alu,alu_mem,mem_wb,ifl,dfl,sel.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] dc_rs1;
    logic [4:0] dc_rs2;
    logic       dc_use_rs1;
    logic       dc_use_rs2;
    logic [4:0] alu_rd;
    logic       alu_is_load;
    logic       alu_br_taken;
    logic       mem_req;
    logic       mem_ack;
    logic       pc_en;
    logic       if_dc_en;
    logic       dc_alu_en;
    logic       alu_mem_en;
    logic       mem_wb_en;
    logic       if_dc_flush;
    logic       dc_alu_flush;
    logic       pc_sel_br;
    logic       mem_timeout;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [7:0] P_IDLE   = 8'b00000_110;
    localparam logic [7:0] P_NORMAL = 8'b11111_000;
    localparam logic [7:0] P_FROZEN = 8'b00000_000;
    localparam logic [7:0] P_BRANCH = 8'b11111_111;
    localparam logic [7:0] P_LU     = 8'b00111_010;
    localparam logic [7:0] M_LU     = 8'b11011_111;

    logic [7:0] obs;
    assign obs = {pc_en, if_dc_en, dc_alu_en, alu_mem_en, mem_wb_en,
                  if_dc_flush, dc_alu_flush, pc_sel_br};

    hazard_ctrl #(.MEM_TIMEOUT(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dc_rs1         (dc_rs1),
        .dc_rs2         (dc_rs2),
        .dc_use_rs1     (dc_use_rs1),
        .dc_use_rs2     (dc_use_rs2),
        .alu_rd         (alu_rd),
        .alu_is_load    (alu_is_load),
        .alu_br_taken   (alu_br_taken),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .pc_en          (pc_en),
        .if_dc_en       (if_dc_en),
        .dc_alu_en      (dc_alu_en),
        .alu_mem_en     (alu_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_dc_flush    (if_dc_flush),
        .dc_alu_flush   (dc_alu_flush),
        .pc_sel_br      (pc_sel_br),
        .mem_timeout    (mem_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dc_rs1       = '0;
        dc_rs2       = '0;
        dc_use_rs1   = 1'b0;
        dc_use_rs2   = 1'b0;
        alu_rd       = '0;
        alu_is_load  = 1'b0;
        alu_br_taken = 1'b0;
        mem_req      = 1'b0;
        mem_ack      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        total_cnt++;
        if (obs !== P_IDLE)
            $display("FAIL reset_outputs got=%b exp=%b", obs, P_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (mem_timeout !== 1'b0 || perf_stall_cnt !== 32'd0
            || perf_flush_cnt !== 32'd0)
            $display("FAIL reset_regs to=%b st=%0d fl=%0d exp=0",
                     mem_timeout, perf_stall_cnt, perf_flush_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_IDLE)
            $display("FAIL init_cycle got=%b exp=%b", obs, P_IDLE);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL run_after_init got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        alu_is_load = 1'b1;
        alu_rd      = 5'd5;
        dc_rs2      = 5'd5;
        dc_use_rs2  = 1'b1;
        #1;
        total_cnt++;
        if ((obs & M_LU) !== (P_LU & M_LU))
            $display("FAIL lu_rs2 got=%b exp=%b", obs, P_LU);
        else pass_cnt++;
        tick();
        alu_is_load = 1'b0;
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL lu_one_cycle got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
        clear_inputs();
        alu_is_load = 1'b1;
        alu_rd      = 5'd7;
        dc_rs1      = 5'd7;
        dc_use_rs1  = 1'b1;
        #1;
        total_cnt++;
        if ((obs & M_LU) !== (P_LU & M_LU))
            $display("FAIL lu_rs1 got=%b exp=%b", obs, P_LU);
        else pass_cnt++;
        tick();
        clear_inputs();
        alu_is_load = 1'b1;
        alu_rd      = 5'd0;
        dc_rs2      = 5'd0;
        dc_use_rs2  = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL lu_x0 got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
        alu_rd     = 5'd9;
        dc_rs1     = 5'd9;
        dc_rs2     = 5'd9;
        dc_use_rs1 = 1'b0;
        dc_use_rs2 = 1'b0;
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL lu_unused got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
        dc_use_rs2  = 1'b1;
        alu_is_load = 1'b0;
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL lu_not_load got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_beats_lu();
        alu_is_load  = 1'b1;
        alu_rd       = 5'd5;
        dc_rs2       = 5'd5;
        dc_use_rs2   = 1'b1;
        alu_br_taken = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_BRANCH)
            $display("FAIL branch_over_lu got=%b exp=%b", obs, P_BRANCH);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL after_branch got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        mem_req = 1'b1;
        mem_ack = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            #1;
            total_cnt++;
            if (obs !== P_FROZEN)
                $display("FAIL to_frozen_%0d got=%b exp=%b", f, obs, P_FROZEN);
            else pass_cnt++;
            tick();
            if (f == 3) begin
                total_cnt++;
                if (mem_timeout !== 1'b0)
                    $display("FAIL to_early got=%b exp=0", mem_timeout);
                else pass_cnt++;
            end
            if (f == 4) begin
                total_cnt++;
                if (mem_timeout !== 1'b1)
                    $display("FAIL to_rise got=%b exp=1", mem_timeout);
                else pass_cnt++;
            end
        end
        mem_ack = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL to_ack got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
        mem_req = 1'b0;
        mem_ack = 1'b0;
        tick();
        total_cnt++;
        if (mem_timeout !== 1'b1)
            $display("FAIL to_sticky got=%b exp=1", mem_timeout);
        else pass_cnt++;
        mem_req = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mem_timeout !== 1'b0 || obs !== P_IDLE)
            $display("FAIL mid_reset to=%b obs=%b exp=0/%b",
                     mem_timeout, obs, P_IDLE);
        else pass_cnt++;
        mem_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_IDLE)
            $display("FAIL mid_reset_init got=%b exp=%b", obs, P_IDLE);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL mid_reset_run got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        logic [31:0] base;
        logic [31:0] exp_st;
        mem_ack = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL ack_no_req got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
        tick();
        base         = perf_stall_cnt;
        mem_req      = 1'b1;
        mem_ack      = 1'b0;
        alu_br_taken = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total_cnt++;
            if (obs !== P_FROZEN)
                $display("FAIL mw_frozen_%0d got=%b exp=%b", c, obs, P_FROZEN);
            else pass_cnt++;
            tick();
        end
        mem_ack = 1'b1;
        #1;
        total_cnt++;
        if (obs !== P_BRANCH)
            $display("FAIL mw_ack_branch got=%b exp=%b", obs, P_BRANCH);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++;
        if (obs !== P_NORMAL)
            $display("FAIL mw_after got=%b exp=%b", obs, P_NORMAL);
        else pass_cnt++;
`ifdef HAZARD_PERF_EN
        exp_st = base + 32'd4;
`else
        exp_st = 32'd0;
`endif
        total_cnt++;
        if (perf_stall_cnt !== exp_st)
            $display("FAIL mw_stall_cnt got=%0d exp=%0d", perf_stall_cnt, exp_st);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_config();
`ifndef HAZARD_PERF_EN
        total_cnt++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0)
            $display("FAIL perf_off st=%0d fl=%0d exp=0",
                     perf_stall_cnt, perf_flush_cnt);
        else pass_cnt++;
`else
        total_cnt++;
        if (perf_flush_cnt == 32'd0)
            $display("FAIL perf_flush got=%0d exp=nonzero", perf_flush_cnt);
        else pass_cnt++;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch_beats_lu();
        test_timeout();
        test_mem_wait();
        test_config();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
